// File: rtl/lsu_stage.sv
// rv32i memory stage: load/store over req/gnt/rvalid, load formatting, one-beat writeback.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and report misalign_o.
//   state  | meaning
//   S_IDLE | accept from execute; non-memory ops pass through in one cycle
//   S_REQ  | mem_req_o high, request fields held until mem_gnt_i
//   S_WAIT | request granted, waiting for mem_rvalid_i
module lsu_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              wb_valid_o,
  output logic              wb_we_o,
  output logic [4:0]        wb_rd_o,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic              misalign_o
);

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_we_q, wb_we_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [DWIDTH-1:0]   wb_data_q, wb_data_d;
  logic                misalign_q, misalign_d;

  logic                ex_is_mem;
  logic                trap_hit;
  logic [1:0]          ex_off, ld_off;
  logic [3:0]          ex_be;
  logic [DWIDTH-1:0]   ld_shifted, ld_data;

  // Lane offset: bytes use addr[1:0], halves addr[1] only, words none.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign trap_hit = ((funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                    (funct3_i[1] && (alu_res_i[1:0] != 2'b00));
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    ex_is_mem  = (opcode_i == OPCODE_LOAD) || (opcode_i == OPCODE_STORE);
    ex_off     = lane_off(funct3_i, alu_res_i[1:0]);
    case (funct3_i[1:0])
      2'b00:   ex_be = 4'b0001 << ex_off;
      2'b01:   ex_be = 4'b0011 << ex_off;
      default: ex_be = 4'b1111;
    endcase
    ld_off     = lane_off(funct3_q, addr_q[1:0]);
    ld_shifted = mem_rdata_i >> {ld_off, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{(DWIDTH-8){ld_shifted[7]}}, ld_shifted[7:0]};
      3'b100:  ld_data = {{(DWIDTH-8){1'b0}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{(DWIDTH-16){ld_shifted[15]}}, ld_shifted[15:0]};
      3'b101:  ld_data = {{(DWIDTH-16){1'b0}}, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid_i) begin
          if (ex_is_mem && trap_hit) begin
            wb_valid_d = 1'b1;
            misalign_d = 1'b1;
            wb_rd_d    = rd_i;
            wb_data_d  = alu_res_i;
          end else if (ex_is_mem) begin
            store_d  = (opcode_i == OPCODE_STORE);
            funct3_d = funct3_i;
            rd_d     = rd_i;
            addr_d   = alu_res_i[AWIDTH-1:0];
            be_d     = ex_be;
            wdata_d  = rs2_i << {ex_off, 3'b000};
            state_d  = S_REQ;
          end else begin
            wb_valid_d = 1'b1;
            wb_we_d    = (opcode_i != OPCODE_BRANCH) && (opcode_i != OPCODE_STORE) && (rd_i != 5'd0);
            wb_rd_d    = rd_i;
            wb_data_d  = alu_res_i;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_we_d    = !store_q && (rd_q != 5'd0);
          wb_data_d  = store_q ? '0 : ld_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      store_q    <= 1'b0;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign ex_ready_o  = (state_q == S_IDLE);
  assign mem_req_o   = (state_q == S_REQ);
  assign mem_we_o    = store_q;
  assign mem_addr_o  = {addr_q[AWIDTH-1:2], 2'b00};
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_we_o     = wb_we_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed vector bench for lsu_stage; follows MISALIGN_TRAP_EN when it is defined.
module tb_lsu_stage;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [31:0] alu_res_i = '0;
  logic [31:0] rs2_i = '0;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        wb_valid_o, wb_we_o, misalign_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  int total = 0;
  int bad = 0;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011, OP_IMM = 7'b0010011;

  lsu_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i), .alu_res_i(alu_res_i), .rs2_i(rs2_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, rs2, rdata;
    int          gw, rw;
    bit          trap;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          wbwe, chkdata;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] rd, logic [31:0] alu,
                              logic [31:0] rs2, logic [31:0] rdata, int gw, int rw, bit trap,
                              logic [31:0] addr, logic [3:0] be, logic [31:0] wdata,
                              bit wbwe, bit chkdata, logic [31:0] data);
    vec_t v;
    v.op = op; v.f3 = f3; v.rd = rd; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
    v.gw = gw; v.rw = rw; v.trap = trap; v.addr = addr; v.be = be; v.wdata = wdata;
    v.wbwe = wbwe; v.chkdata = chkdata; v.data = data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] rs2);
    ex_valid_i = 1'b1; opcode_i = op; funct3_i = f3; rd_i = rd; alu_res_i = alu; rs2_i = rs2;
  endtask

  task automatic apply(input int idx, input vec_t v);
    bit is_mem;
    string p;
    is_mem = (v.op == OP_LOAD) || (v.op == OP_STORE);
    p = $sformatf("v%0d", idx);
    chk({p, "_ready_in"}, ex_ready_o, 1);
    drive_ex(v.op, v.f3, v.rd, v.alu, v.rs2);
    step();
    ex_valid_i = 1'b0;
    if (is_mem && !v.trap) begin
      chk({p, "_req"}, mem_req_o, 1);
      chk({p, "_ready_busy"}, ex_ready_o, 0);
      chk({p, "_we"}, mem_we_o, (v.op == OP_STORE));
      chk({p, "_addr"}, mem_addr_o, v.addr);
      chk({p, "_be"}, mem_be_o, v.be);
      chk({p, "_wdata"}, mem_wdata_o, v.wdata);
      for (int i = 0; i < v.gw; i++) begin
        step();
        chk({p, "_req_hold"}, mem_req_o, 1);
        chk({p, "_addr_hold"}, mem_addr_o, v.addr);
        chk({p, "_be_hold"}, mem_be_o, v.be);
      end
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      chk({p, "_req_drop"}, mem_req_o, 0);
      chk({p, "_ready_wait"}, ex_ready_o, 0);
      for (int i = 0; i < v.rw; i++) begin
        step();
        chk({p, "_ready_wait"}, ex_ready_o, 0);
      end
      chk({p, "_wb_early"}, wb_valid_o, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = v.rdata;
      step();
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
    end else if (is_mem) begin
      chk({p, "_trap_noreq"}, mem_req_o, 0);
    end
    chk({p, "_wb_valid"}, wb_valid_o, 1);
    chk({p, "_wb_we"}, wb_we_o, v.wbwe);
    chk({p, "_misalign"}, misalign_o, v.trap);
    if (!v.trap) chk({p, "_wb_rd"}, wb_rd_o, v.rd);
    if (v.chkdata) chk({p, "_wb_data"}, wb_data_o, v.data);
    step();
    chk({p, "_wb_pulse"}, wb_valid_o, 0);
    chk({p, "_ready_out"}, ex_ready_o, 1);
  endtask

  initial begin
    vecs.push_back(mk(OP_IMM,    3'b000, 5'd3, 32'h5,     0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h5));
    vecs.push_back(mk(OP_BRANCH, 3'b000, 5'd4, 32'h123,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h123));
    vecs.push_back(mk(OP_IMM,    3'b000, 5'd0, 32'hDEAD,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD));
    vecs.push_back(mk(OP_STORE,  3'b000, 5'd0, 32'h1002, 32'hAB, 0, 0, 0, 0,
                      32'h1000, 4'b0100, 32'h00AB_0000, 0, 0, 0));
    vecs.push_back(mk(OP_LOAD,   3'b000, 5'd5, 32'h2003, 0, 32'h8000_0000, 0, 0, 0,
                      32'h2000, 4'b1000, 0, 1, 1, 32'hFFFF_FF80));
    vecs.push_back(mk(OP_LOAD,   3'b100, 5'd5, 32'h2003, 0, 32'h8000_0000, 0, 0, 0,
                      32'h2000, 4'b1000, 0, 1, 1, 32'h0000_0080));
    vecs.push_back(mk(OP_LOAD,   3'b101, 5'd6, 32'h2002, 0, 32'hBEEF_0000, 0, 0, 0,
                      32'h2000, 4'b1100, 0, 1, 1, 32'h0000_BEEF));
    vecs.push_back(mk(OP_LOAD,   3'b000, 5'd7, 32'h2001, 0, 32'h0000_7F00, 1, 1, 0,
                      32'h2000, 4'b0010, 0, 1, 1, 32'h0000_007F));
    vecs.push_back(mk(OP_LOAD,   3'b001, 5'd9, 32'h2000, 0, 32'h0000_8001, 0, 0, 0,
                      32'h2000, 4'b0011, 0, 1, 1, 32'hFFFF_8001));
    vecs.push_back(mk(OP_STORE,  3'b001, 5'd0, 32'h2002, 32'h1234_5678, 0, 0, 1, 0,
                      32'h2000, 4'b1100, 32'h5678_0000, 0, 0, 0));
    vecs.push_back(mk(OP_STORE,  3'b010, 5'd1, 32'h4000, 32'hCAFE_BABE, 0, 2, 2, 0,
                      32'h4000, 4'b1111, 32'hCAFE_BABE, 0, 0, 0));
    vecs.push_back(mk(OP_LOAD,   3'b010, 5'd8, 32'h4004, 0, 32'h1357_9BDF, 3, 1, 0,
                      32'h4004, 4'b1111, 0, 1, 1, 32'h1357_9BDF));
    vecs.push_back(mk(OP_LOAD,   3'b010, 5'd0, 32'h4008, 0, 32'h1234_5678, 0, 0, 0,
                      32'h4008, 4'b1111, 0, 0, 1, 32'h1234_5678));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(OP_LOAD,   3'b010, 5'd7, 32'h3001, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h3001));
    vecs.push_back(mk(OP_LOAD,   3'b001, 5'd7, 32'h2003, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h2003));
    vecs.push_back(mk(OP_LOAD,   3'b011, 5'd6, 32'h4000, 0, 32'hA5A5_0001, 0, 0, 0,
                      32'h4000, 4'b1111, 0, 1, 1, 32'hA5A5_0001));
`else
    vecs.push_back(mk(OP_LOAD,   3'b010, 5'd7, 32'h3001, 0, 32'h0BAD_F00D, 1, 0, 0,
                      32'h3000, 4'b1111, 0, 1, 1, 32'h0BAD_F00D));
    vecs.push_back(mk(OP_LOAD,   3'b001, 5'd7, 32'h2003, 0, 32'h8000_0000, 0, 0, 0,
                      32'h2000, 4'b1100, 0, 1, 1, 32'hFFFF_8000));
    vecs.push_back(mk(OP_LOAD,   3'b011, 5'd6, 32'h4003, 0, 32'hA5A5_0001, 0, 0, 0,
                      32'h4000, 4'b1111, 0, 1, 1, 32'hA5A5_0001));
`endif

    #2;
    chk("rst_ready", ex_ready_o, 1);
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_be", mem_be_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_we", wb_we_o, 0);
    chk("rst_wb_rd", wb_rd_o, 0);
    chk("rst_wb_data", wb_data_o, 0);
    chk("rst_misalign", misalign_o, 0);
    #10 reset_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // back-to-back pass-through
    drive_ex(OP_IMM, 3'b000, 5'd1, 32'h11, 0);
    step();
    chk("b2b_wb1", wb_data_o, 32'h11);
    chk("b2b_rd1", wb_rd_o, 5'd1);
    chk("b2b_ready1", ex_ready_o, 1);
    drive_ex(OP_IMM, 3'b000, 5'd2, 32'h22, 0);
    step();
    chk("b2b_valid2", wb_valid_o, 1);
    chk("b2b_wb2", wb_data_o, 32'h22);
    chk("b2b_rd2", wb_rd_o, 5'd2);
    drive_ex(OP_STORE - 7'd0 == OP_STORE ? OP_BRANCH : OP_IMM, 3'b000, 5'd3, 32'h33, 0);
    step();
    ex_valid_i = 1'b0;
    chk("b2b_valid3", wb_valid_o, 1);
    chk("b2b_wb3", wb_data_o, 32'h33);
    chk("b2b_we3", wb_we_o, 0);
    step();
    chk("b2b_idle", wb_valid_o, 0);

    // reset while waiting for the response; a late rvalid must be ignored
    drive_ex(OP_LOAD, 3'b010, 5'd9, 32'h5000, 0);
    step();
    ex_valid_i = 1'b0;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    chk("rw_in_wait", ex_ready_o, 0);
    reset_n = 1'b0;
    #1;
    chk("rw_ready", ex_ready_o, 1);
    chk("rw_req", mem_req_o, 0);
    chk("rw_addr", mem_addr_o, 0);
    chk("rw_wb_valid", wb_valid_o, 0);
    #2 reset_n = 1'b1;
    step();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFF_FFFF;
    step();
    mem_rvalid_i = 1'b0;
    chk("rw_stray_wb", wb_valid_o, 0);
    chk("rw_stray_req", mem_req_o, 0);
    step();
    chk("rw_stray_wb2", wb_valid_o, 0);
    chk("rw_ready2", ex_ready_o, 1);

    // reset during REQ drops mem_req_o without a clock edge
    drive_ex(OP_STORE, 3'b010, 5'd0, 32'h6000, 32'h1);
    step();
    ex_valid_i = 1'b0;
    chk("rr_req_on", mem_req_o, 1);
    reset_n = 1'b0;
    #1;
    chk("rr_req_off", mem_req_o, 0);
    chk("rr_we_off", mem_we_o, 0);
    #2 reset_n = 1'b1;
    step();
    chk("rr_ready", ex_ready_o, 1);
    chk("rr_req_idle", mem_req_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
